aes_key_schedule_seq: RTL and testbench
=======================================

// Module: aes_key_schedule_seq
// PURPOSE
// - Sequential AES key schedule for AES-128/192/256, key length selected per run (not per build).
// - Expands one 32-bit word per clock into an internal word store.
// - Serves 128-bit round keys by round index to the cipher datapath over a registered read port.
// - Replaces the fully combinational expander: one shared 4-byte S-box path instead of 4*Nr.
// PARAMETERS
// - MAX_NK  8   largest key length in words; fixes `key` width at 32*MAX_NK.
// - MAX_NR  14  largest round count; the store holds 4*MAX_NR+4 = 60 words.
// PORTS
// - clk       in   1            clock; all state updates on posedge.
// - rst_n     in   1            asynchronous active-low reset.
// - start     in   1            request expansion; sampled only in IDLE.
// - key_len   in   2            0=128b (Nk4,Nr10), 1=192b (Nk6,Nr12), 2=256b (Nk8,Nr14), 3=illegal.
// - key       in   32*MAX_NK    key, MSB-first: w[0]=key[255:224]; unused low bits ignored; sampled with start.
// - busy      out  1            expansion in progress.
// - ready     out  1            store holds a complete schedule for the latched key_len.
// - err       out  1            1-cycle pulse: start with key_len==3, or illegal read.
// - rk_req    in   1            round-key read request.
// - rk_idx    in   4            round index 0..Nr.
// - rk        out  128          round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}; valid one cycle after rk_req.
// - rk_valid  out  1            1-cycle pulse qualifying rk.
// - zeroize   in   1            present only with AES_KS_ZEROIZE_EN.
// BEHAVIOUR
// - Reset: FSM=IDLE; busy/ready/err/rk_valid=0; rk=0; word store contents undefined (zeroed only under the macro).
// - FSM IDLE->LOAD->EXPAND->IDLE.
//   - IDLE + start + legal key_len: latch Nk/Nr, clear ready, go to LOAD.
//   - IDLE + start + key_len==3: err pulse next cycle, stay IDLE, ready unchanged.
// - LOAD (1 cycle): write w[0..Nk-1]; i=Nk; mod-Nk counter=0; rcon=8'h01.
// - EXPAND: one word per cycle, w[i] = w[i-Nk] ^ f(w[i-1]).
//   - If i%Nk==0: f = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon=xtime(rcon).
//   - Else if Nk==8 and i%Nk==4: f = SubWord(t).
//   - Else: f = t.
//   - i%Nk comes from a wrap counter, not a divider; xtime is {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 0).
//   - On the cycle writing i==4*Nr+3: go to IDLE, drop busy, set ready the next cycle.
// - Timing: busy high from the cycle after start through the last write; ready rises 41/47/53 cycles after start for 128/192/256.
// - start while busy is ignored; no restart and no err.
// - Read: rk_req while ready and rk_idx<=Nr -> next cycle rk=store, rk_valid=1.
//   - Read with !ready or rk_idx>Nr -> next cycle rk=0, rk_valid=0, err=1.
//   - rk holds its value until the next accepted read.
// - Async reset mid-expansion aborts: IDLE, ready=0; partial store contents are never served.
// CONFIGURATION
// - AES_KS_ZEROIZE_EN defined:
//   - zeroize port exists; zeroize has priority over start and rk_req in every state.
//   - Clears all 60 words, rk and ready on the next edge; FSM->IDLE, busy=0.
//   - Reset also clears the store.
// - AES_KS_ZEROIZE_EN undefined: no zeroize port; store is not cleared.
// STRUCTURE
// - aes_pkg (shared): key_len_e enum; NK/NR lookup constants; xtime function; RCON_INIT=8'h01.
// - Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4x for SubWord.
//   - Same sub-module is reused by the cipher SubBytes.
// - Word store: flop array 60x32, one write port, one 4-word read port.
// TESTING
// - Run FIPS-197 A.1, 128b, key 2b7e151628aed2a6abf7158809cf4f3c:
//   ready after 41 cycles; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
// - Run FIPS-197 A.2, 192b, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//   rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
// - Run FIPS-197 A.3, 256b, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//   rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
// - 128b run, then rk_idx=11 -> err=1, rk_valid=0.
//   - Then key_len=3 with start -> err pulse, ready stays 1.
// - Assert rst_n low at cycle 20 of a 256b run -> busy=0, ready=0.
//   - Then a rk_req -> err=1.
//   - A new 128b run then gives the A.1 result.
// - AES_KS_ZEROIZE_EN: zeroize after a completed A.1 -> ready=0, rk=0.
//   - A read then errs; a new start works.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, Nk/Nr lookups and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2,
        KL_BAD = 2'd3
    } key_len_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;
    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(key_len_e kl);
        case (kl)
            KL_192:  return NK_192;
            KL_256:  return NK_256;
            default: return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_len_e kl);
        case (kl)
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte); shared with the cipher SubBytes path.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one expanded word per clock, round keys served by index.
// Optional AES_KS_ZEROIZE_EN adds a zeroize port that wipes the word store, rk and ready.
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int unsigned MAX_NK = 8,
    parameter int unsigned MAX_NR = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key,
    output logic                  busy,
    output logic                  ready,
    output logic                  err,
    input  logic                  rk_req,
    input  logic [3:0]            rk_idx,
    output logic [127:0]          rk,
    output logic                  rk_valid
`ifdef AES_KS_ZEROIZE_EN
    ,
    input  logic                  zeroize
`endif
);

    localparam int unsigned NWORDS = 4*MAX_NR + 4;
    localparam int unsigned IW     = $clog2(NWORDS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    nk_q, nk_d, nr_q, nr_d;
    logic [IW-1:0] i_q, i_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          ready_q, ready_d, err_q, err_d, rk_valid_q, rk_valid_d;
    logic [127:0]  rk_q, rk_d;
    logic [31:0]   store_q [NWORDS];
    logic [31:0]   store_d [NWORDS];

    logic          zero_w;
`ifdef AES_KS_ZEROIZE_EN
    assign zero_w = zeroize;
`else
    assign zero_w = 1'b0;
`endif

    // Expansion datapath: f(w[i-1]) through a single 4-byte S-box
    logic [31:0]   prev_w, back_w, sb_in, sb_out, f_w, new_w;
    logic [IW-1:0] last_idx, rd_base;

    assign prev_w   = store_q[i_q - IW'(1)];
    assign back_w   = store_q[i_q - IW'(nk_q)];
    assign sb_in    = (cnt_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    assign last_idx = IW'({nr_q, 2'b00}) + IW'(3);
    assign rd_base  = IW'({rk_idx, 2'b00});

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a_i(sb_in[8*b +: 8]), .y_o(sb_out[8*b +: 8]));
    end

    always_comb begin
        f_w = prev_w;
        if (cnt_q == 3'd0)
            f_w = sb_out ^ {rcon_q, 24'h0};
        else if (nk_q == NK_256 && cnt_q == 3'd4)
            f_w = sb_out;
        new_w = back_w ^ f_w;
    end

    always_comb begin
        state_d    = state_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        i_d        = i_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        ready_d    = ready_q;
        err_d      = 1'b0;
        rk_d       = rk_q;
        rk_valid_d = 1'b0;
        store_d    = store_q;

        if (zero_w) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            rk_d    = '0;
            for (int unsigned k = 0; k < NWORDS; k++) store_d[k] = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == KL_BAD) begin
                            err_d = 1'b1;
                        end else begin
                            nk_d    = nk_of(key_len_e'(key_len));
                            nr_d    = nr_of(key_len_e'(key_len));
                            ready_d = 1'b0;
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    for (int unsigned k = 0; k < MAX_NK; k++)
                        if (k < 32'(nk_q)) store_d[k] = key[32*MAX_NK-1-32*k -: 32];
                    i_d     = IW'(nk_q);
                    cnt_d   = '0;
                    rcon_d  = RCON_INIT;
                    state_d = S_EXPAND;
                end
                S_EXPAND: begin
                    store_d[i_q] = new_w;
                    i_d   = i_q + IW'(1);
                    cnt_d = ({1'b0, cnt_q} == nk_q - 4'd1) ? 3'd0 : cnt_q + 3'd1;
                    if (cnt_q == 3'd0) rcon_d = xtime(rcon_q);
                    if (i_q == last_idx) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Reads are decided on the current ready, so a read racing a new start sees the old schedule
            if (rk_req) begin
                if (ready_q && rk_idx <= nr_q) begin
                    rk_d       = {store_q[rd_base], store_q[rd_base + IW'(1)],
                                  store_q[rd_base + IW'(2)], store_q[rd_base + IW'(3)]};
                    rk_valid_d = 1'b1;
                end else begin
                    rk_d  = '0;
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            nk_q       <= NK_128;
            nr_q       <= NR_128;
            i_q        <= '0;
            cnt_q      <= '0;
            rcon_q     <= RCON_INIT;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            i_q        <= i_d;
            cnt_q      <= cnt_d;
            rcon_q     <= rcon_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
        end
    end

`ifdef AES_KS_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NWORDS; k++) store_q[k] <= '0;
        end else begin
            store_q <= store_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        store_q <= store_d;
    end
`endif

    assign busy     = (state_q != S_IDLE);
    assign ready    = ready_q;
    assign err      = err_q;
    assign rk       = rk_q;
    assign rk_valid = rk_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq using FIPS-197 Appendix A vectors.
// Zeroize checks are compiled in when AES_KS_ZEROIZE_EN is defined.
module tb_aes_key_schedule_seq;

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] A2_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] A2_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] A2_R1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] A2_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] A3_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_R2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key = '0;
    logic         rk_req = 1'b0;
    logic [3:0]   rk_idx = 4'd0;
    logic         busy, ready, err, rk_valid;
    logic [127:0] rk;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit           err;
        bit           chk_rk;
        logic [127:0] rk;
        string        name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.MAX_NK(8), .MAX_NR(14)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key      (key),
        .busy     (busy),
        .ready    (ready),
        .err      (err),
        .rk_req   (rk_req),
        .rk_idx   (rk_idx),
        .rk       (rk),
        .rk_valid (rk_valid)
`ifdef AES_KS_ZEROIZE_EN
        ,
        .zeroize  (zeroize)
`endif
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every rk_valid or err pulse must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rk_valid === 1'b1 || err === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got rk_valid=%b err=%b rk=%h expected no output",
                             rk_valid, err, rk);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    if (err !== e.err || rk_valid !== !e.err || (e.chk_rk && rk !== e.rk)) begin
                        n_bad++;
                        $display("FAIL %s: got err=%b rk_valid=%b rk=%h expected err=%b rk_valid=%b rk=%h",
                                 e.name, err, rk_valid, rk, e.err, !e.err, e.rk);
                    end
                end
            end
        end
    end

    // Called just after a posedge; returns just after the edge where ready rose.
    task automatic run_key(input logic [1:0] kl, input logic [255:0] k, input int exp_cyc,
                           input bit poke, input string nm);
        int cyc;
        start = 1'b1; key_len = kl; key = k;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_busy_start"}, busy, 1);
        check({nm, "_ready_clr"}, ready, 0);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            if (poke && cyc == 5) begin
                start = 1'b1; key_len = 2'd0; key = {A1_KEY, 128'h0};
            end
            @(posedge clk); #1;
            start = 1'b0; key_len = kl; key = k;
            cyc++;
        end
        check({nm, "_ready_latency"}, 128'(cyc), 128'(exp_cyc));
        check({nm, "_busy_done"}, busy, 0);
    endtask

    task automatic rd(input logic [3:0] idx, input bit e_err, input logic [127:0] e_rk,
                      input bit chk, input string nm);
        exp_t e;
        e.err = e_err; e.chk_rk = chk; e.rk = e_rk; e.name = nm;
        sb.push_back(e);
        rk_req = 1'b1; rk_idx = idx;
        @(posedge clk); #1;
        rk_req = 1'b0;
        check({nm, "_lat"}, rk_valid | err, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_rk_valid", rk_valid, 0);
        check("rst_rk", rk, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_key(2'd0, {A1_KEY, 128'h0}, 41, 0, "a1");
        rd(4'd10, 0, A1_R10, 1, "a1_rk10");
        rd(4'd0,  0, A1_KEY, 1, "a1_rk0");
        rd(4'd1,  0, A1_R1,  1, "a1_rk1");
        rd(4'd11, 1, '0,     1, "a1_idx11_err");

        sb.push_back('{err: 1'b1, chk_rk: 1'b0, rk: '0, name: "bad_keylen_err"});
        start = 1'b1; key_len = 2'd3;
        @(posedge clk); #1;
        start = 1'b0; key_len = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("bad_keylen_ready", ready, 1);
        check("bad_keylen_busy", busy, 0);

        run_key(2'd1, {A2_KEY, 64'h0}, 47, 0, "a2");
        rd(4'd12, 0, A2_R12, 1, "a2_rk12");
        rd(4'd0,  0, A2_R0,  1, "a2_rk0");
        rd(4'd1,  0, A2_R1,  1, "a2_rk1");
        rd(4'd13, 1, '0,     1, "a2_idx13_err");

        // Includes a legal start mid-run, which must be ignored
        run_key(2'd2, A3_KEY, 53, 1, "a3");
        rd(4'd14, 0, A3_R14, 1, "a3_rk14");
        rd(4'd1,  0, A3_R1,  1, "a3_rk1");
        rd(4'd2,  0, A3_R2,  1, "a3_rk2");
        rd(4'd15, 1, '0,     1, "a3_idx15_err");

        start = 1'b1; key_len = 2'd2; key = A3_KEY;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_hold", ready, 0);
        rd(4'd10, 1, '0, 1, "abort_rd_err");
        run_key(2'd0, {A1_KEY, 128'h0}, 41, 0, "a1b");
        rd(4'd10, 0, A1_R10, 1, "a1b_rk10");

`ifdef AES_KS_ZEROIZE_EN
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        check("zero_ready", ready, 0);
        check("zero_rk", rk, 0);
        check("zero_busy", busy, 0);
        rd(4'd10, 1, '0, 1, "zero_rd_err");
        run_key(2'd0, {A1_KEY, 128'h0}, 41, 0, "a1z");
        rd(4'd10, 0, A1_R10, 1, "a1z_rk10");
`endif

        repeat (4) @(posedge clk);
        #1;
        check("sb_drain", 128'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
